inst_fetch_queue: RTL and testbench

- Instruction buffer between the fetch unit and the decode stage.
- Accepts {PC, instruction} pairs from fetch over a valid/ready handshake, stores up to DEPTH entries in order, and presents the oldest entry to decode with pre-extracted RV32I fields and an illegal-opcode flag.
- Absorbs decode stalls without losing fetched words.
- Supports a one-cycle flush for branch/jump redirects.

---
 rtl/inst_fetch_queue.sv | 167 ++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_queue
//  Description : In-order instruction buffer between fetch and decode.
//                It accepts {PC, instruction} pairs over valid/ready and
//                stores up to DEPTH entries. The oldest entry is presented
//                with its RV32I fields already split out and with an
//                illegal-opcode flag. A one-cycle flush discards the whole
//                queue on a redirect.
//                Optional macro IFQ_BYPASS_EN: when the queue is empty and
//                decode is ready, the incoming word passes straight through
//                in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_WORD = 32'h00000013
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [XLEN-1:0]         in_instr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_instr,
    output logic [6:0]              out_opcode,
    output logic [4:0]              out_rd,
    output logic [2:0]              out_funct3,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [6:0]              out_funct7,
    output logic                    out_illegal,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;

    localparam logic [c_lvl_w-1:0] c_full    = c_lvl_w'(DEPTH);
    localparam logic [c_lvl_w-1:0] c_lvl_one = c_lvl_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    // RV32I base opcodes
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_fence  = 7'b0001111;
    localparam logic [6:0] c_op_system = 7'b1110011;

    // Entry storage. It is not reset because occupancy alone decides validity.
    logic [XLEN-1:0]    r_pc_mem    [0:DEPTH-1];
    logic [XLEN-1:0]    r_instr_mem [0:DEPTH-1];

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;

    logic w_empty;
    logic w_full;
    logic w_head_valid;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_legal;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_full);

    // in_ready depends only on stored state and flush. It never depends on
    // out_ready, so a pop in the same cycle cannot open a full queue.
    assign in_ready     = ~w_full & ~flush;
    assign w_head_valid = ~w_empty & ~flush;

`ifdef IFQ_BYPASS_EN
    // Empty queue and ready decode: the word is consumed as it arrives
    assign w_bypass = w_empty & in_valid & out_ready & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word is consumed directly, so it is neither stored nor popped
    assign w_push = in_valid & in_ready & ~w_bypass;
    assign w_pop  = w_head_valid & out_ready;

    assign out_valid = w_head_valid | w_bypass;
    assign level     = r_level;

    // Head selection: stored entry, bypassed input, or the idle NOP/zero-PC value
    always_comb begin
        out_pc    = '0;
        out_instr = NOP_WORD;
        if (w_head_valid) begin
            out_pc    = r_pc_mem[r_rd_ptr];
            out_instr = r_instr_mem[r_rd_ptr];
        end else if (w_bypass) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end
    end

    assign out_opcode = out_instr[6:0];
    assign out_rd     = out_instr[11:7];
    assign out_funct3 = out_instr[14:12];
    assign out_rs1    = out_instr[19:15];
    assign out_rs2    = out_instr[24:20];
    assign out_funct7 = out_instr[31:25];

    // Opcode legality check against the RV32I base set
    always_comb begin
        w_legal = 1'b0;
        case (out_opcode)
            c_op_lui, c_op_auipc, c_op_jal, c_op_jalr, c_op_branch,
            c_op_load, c_op_store, c_op_opimm, c_op_op, c_op_fence,
            c_op_system: w_legal = 1'b1;
            default:     w_legal = 1'b0;
        endcase
    end

    // The NOP head (empty or flushing) is legal; only a valid head is flagged
    assign out_illegal = out_valid & ~w_legal;

    // Write the accepted word into the slot at the write pointer
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_instr_mem[r_wr_ptr] <= in_instr;
        end
    end

    // Pointer and occupancy tracking. Flush resets the queue to empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_queue
//  Description : Self-checking bench for inst_fetch_queue. A queue-based
//                reference model predicts every visible output. The bench
//                runs directed scenarios first and then a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

    localparam int          DEPTH = 4;
    localparam int          XLEN  = 32;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic        out_illegal;
    logic [2:0]  level;

    inst_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP_WORD(NOP)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
        .out_illegal(out_illegal), .level(level)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t model_q[$];
    int     vectors     = 0;
    int     miscompares = 0;
    bit     last_taken;

    logic [6:0] legal_ops [0:10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                     7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                     7'b0110011, 7'b0001111, 7'b1110011};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        bit hit = 0;
        for (int k = 0; k < 11; k++) if (legal_ops[k] == op) hit = 1;
        return hit;
    endfunction

    // One cycle: drive inputs after the falling edge, check the outputs,
    // let the rising edge happen, update the model, and return at the
    // next falling edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl);
        bit          exp_ready, exp_valid, head_ok, byp;
        logic [31:0] e_pc, e_instr;
        in_valid = v; in_pc = pc; in_instr = ins; out_ready = rdy; flush = fl;
        #1;
        exp_ready = (model_q.size() != DEPTH) && !fl;
        head_ok   = (model_q.size() != 0) && !fl;
        byp       = 0;
`ifdef IFQ_BYPASS_EN
        byp = (model_q.size() == 0) && v && rdy && !fl;
`endif
        exp_valid = head_ok || byp;
        if (head_ok) begin
            e_pc = model_q[0].pc; e_instr = model_q[0].instr;
        end else if (byp) begin
            e_pc = pc; e_instr = ins;
        end else begin
            e_pc = 32'h0; e_instr = NOP;
        end
        check("level", 32'(level), 32'(model_q.size()));
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("out_pc", out_pc, e_pc);
        check("out_instr", out_instr, e_instr);
        check("out_illegal", 32'(out_illegal), 32'(exp_valid && !is_legal(e_instr[6:0])));
        if (exp_valid) begin
            check("out_opcode", 32'(out_opcode), 32'(e_instr[6:0]));
            check("out_rd", 32'(out_rd), 32'(e_instr[11:7]));
            check("out_funct3", 32'(out_funct3), 32'(e_instr[14:12]));
            check("out_rs1", 32'(out_rs1), 32'(e_instr[19:15]));
            check("out_rs2", 32'(out_rs2), 32'(e_instr[24:20]));
            check("out_funct7", 32'(out_funct7), 32'(e_instr[31:25]));
        end
        last_taken = byp || (v && exp_ready);
        @(posedge clock);
        if (fl) begin
            model_q.delete();
        end else if (!byp) begin
            if (head_ok && rdy) void'(model_q.pop_front());
            if (v && exp_ready) model_q.push_back('{pc: pc, instr: ins});
        end
        @(negedge clock);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 1) == 1) w[6:0] = legal_ops[$urandom_range(0, 10)];
        return w;
    endfunction

    logic [31:0] fill_ins [0:3] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000073};

    initial begin
        logic [31:0] pc;
        logic [31:0] cur_pc, cur_ins;
        bit          pending;
        logic        v, rdy, fl;

        reset = 1'b1; flush = 0; in_valid = 0; out_ready = 0; in_pc = 0; in_instr = 0;
        @(posedge clock); @(posedge clock); #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, NOP);
        check("rst_out_pc", out_pc, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        idle();

        // Fill to full, then offer a fifth word that must be held off
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), fill_ins[i], 1'b0, 1'b0);
        step(1'b1, 32'h10, 32'h00100013, 1'b0, 1'b0);
        check("full_level", 32'(level), 32'd4);

        // Drain in order, then confirm the queue is empty
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        // Build level 2 with the write pointer at 3, then stream across the wrap
        pc = 32'h200;
        for (int i = 0; i < 3; i++) begin step(1'b1, pc, 32'h00000013 | (i << 7), 1'b0, 1'b0); pc += 4; end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin step(1'b1, pc, 32'h00000033 | (i << 7), 1'b1, 1'b0); pc += 4; end
        check("wrap_level", 32'(level), 32'd2);

        // Flush at level 3 with both handshakes requested
        step(1'b1, pc, 32'h00000013, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD0000, 32'h00000013, 1'b1, 1'b1);
        step(1'b1, 32'h100, 32'h00300193, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        // Illegal flag on an all-ones word and on a NOP
        step(1'b1, 32'h400, 32'hFFFFFFFF, 1'b0, 1'b0);
        step(1'b1, 32'h404, 32'h00000013, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Empty queue with decode ready; passes through when bypass is built in
        step(1'b1, 32'h300, 32'h00A00113, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle with three entries queued
        for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + 32'(i * 4), 32'h00000013, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("arst_level", 32'(level), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_instr", out_instr, NOP);
        model_q.delete();
        @(negedge clock);
        reset = 1'b0;
        idle();
        idle();

        // Randomized traffic; fetch holds an offered word until it is taken
        pc = 32'h1000; pending = 0; cur_pc = 0; cur_ins = 0;
        for (int n = 0; n < 400; n++) begin
            if (!pending) begin
                cur_pc = pc; cur_ins = rand_instr();
                pending = ($urandom_range(0, 9) < 7);
            end
            v   = pending;
            rdy = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 29) == 0);
            step(v, cur_pc, cur_ins, rdy, fl);
            if (v && last_taken) begin pending = 0; pc += 4; end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
